// File: rtl/jpeg_entropy_pkg.sv
// Shared JPEG entropy-coding constants: DC Huffman tables (JPEG Annex K.3),
// the size-category helper and the output length width, shared with the AC encoder.
package jpeg_entropy_pkg;

  localparam int unsigned LEN_W       = 5;
  localparam int unsigned DC_CODE_W   = 11;
  localparam int unsigned DC_MAX_SIZE = 11;

  typedef enum logic {
    TBL_LUMA   = 1'b0,
    TBL_CHROMA = 1'b1
  } dc_tbl_e;

  // Codes are right-aligned; the matching length gives the number of valid bits.
  localparam logic [DC_CODE_W-1:0] DC_LUMA_CODE [12] = '{
    11'h000, 11'h002, 11'h003, 11'h004, 11'h005, 11'h006,
    11'h00E, 11'h01E, 11'h03E, 11'h07E, 11'h0FE, 11'h1FE
  };
  localparam logic [3:0] DC_LUMA_LEN [12] = '{
    4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
  };
  localparam logic [DC_CODE_W-1:0] DC_CHROMA_CODE [12] = '{
    11'h000, 11'h001, 11'h002, 11'h006, 11'h00E, 11'h01E,
    11'h03E, 11'h07E, 11'h0FE, 11'h1FE, 11'h3FE, 11'h7FE
  };
  localparam logic [3:0] DC_CHROMA_LEN [12] = '{
    4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11
  };

  // Size category: bit length of an unsigned magnitude (0 for 0).
  function automatic logic [3:0] size_cat(input logic [11:0] mag);
    logic [3:0] s;
    s = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/dc_huff_lut.sv
// Combinational DC Huffman lookup: size category and table select -> code and length.
module dc_huff_lut
  import jpeg_entropy_pkg::*;
(
  input  logic [3:0]           size,
  input  dc_tbl_e              tbl,
  output logic [DC_CODE_W-1:0] code,
  output logic [3:0]           len
);

  always_comb begin
    code = '0;
    len  = '0;
    if (size <= 4'(DC_MAX_SIZE)) begin
      if (tbl == TBL_LUMA) begin
        code = DC_LUMA_CODE[size];
        len  = DC_LUMA_LEN[size];
      end else begin
        code = DC_CHROMA_CODE[size];
        len  = DC_CHROMA_LEN[size];
      end
    end
  end

endmodule

// File: rtl/dc_huff_encoder.sv
// JPEG baseline DC encoder: per-channel prediction, size category, Huffman code plus
// magnitude bits emitted MSB-aligned through a two-stage valid/ready pipeline.
module dc_huff_encoder
  import jpeg_entropy_pkg::*;
#(
  parameter int unsigned COEF_W = 11,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned CODE_W = 2 * COEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_dc,
  input  logic [CH_W-1:0]          in_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_bits,
  output logic [LEN_W-1:0]         out_len,
  output logic [3:0]               out_size,
  output logic [CH_W-1:0]          out_ch,
  output logic                     err_ch
);

  localparam int unsigned DW = COEF_W + 1;

  logic                     adv, fire, ch_ok;
  logic signed [COEF_W-1:0] pred [NUM_CH];
  logic signed [COEF_W-1:0] pred_sel;
  logic signed [DW-1:0]     diff;

  logic                     s1_valid;
  logic signed [DW-1:0]     s1_diff;
  logic [CH_W-1:0]          s1_ch;

  logic [DW-1:0]            abs_diff, mag_src;
  logic [3:0]               size;
  dc_tbl_e                  tbl;
  logic [DC_CODE_W-1:0]     code;
  logic [3:0]               code_len;
  logic [CODE_W-1:0]        mag_mask, word, bits;
  logic [LEN_W-1:0]         len;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign fire     = in_valid && adv;
  assign ch_ok    = 32'(in_ch) < NUM_CH;

  // A restart in the accept cycle takes effect before the difference is formed.
  always_comb begin
    pred_sel = '0;
    if (!restart) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (in_ch == CH_W'(i)) pred_sel = pred[i];
      end
    end
    diff = {in_dc[COEF_W-1], in_dc} - {pred_sel[COEF_W-1], pred_sel};
  end

  always_comb begin
    abs_diff = s1_diff[DW-1] ? DW'(-s1_diff) : s1_diff;
    mag_src  = s1_diff[DW-1] ? (s1_diff - DW'(1)) : s1_diff;
    size     = size_cat(12'(abs_diff));
    tbl      = (s1_ch == '0) ? TBL_LUMA : TBL_CHROMA;
  end

  dc_huff_lut u_lut (
    .size (size),
    .tbl  (tbl),
    .code (code),
    .len  (code_len)
  );

  // Build {code, magnitude} right-aligned, then shift it up to the MSB end.
  always_comb begin
    mag_mask = (CODE_W'(1) << size) - CODE_W'(1);
    word     = (CODE_W'(code) << size) | (CODE_W'(mag_src) & mag_mask);
    len      = LEN_W'(code_len) + LEN_W'(size);
    bits     = word << (LEN_W'(CODE_W) - len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_ch     <= '0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_len   <= '0;
      out_size  <= '0;
      out_ch    <= '0;
      err_ch    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) pred[i] <= '0;
    end else begin
      err_ch <= fire && !ch_ok;
      if (restart) begin
        for (int unsigned i = 0; i < NUM_CH; i++) pred[i] <= '0;
      end
      if (fire && ch_ok) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (in_ch == CH_W'(i)) pred[i] <= in_dc;
        end
      end
      if (adv) begin
        s1_valid  <= fire && ch_ok;
        s1_diff   <= diff;
        s1_ch     <= in_ch;
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_bits <= bits;
          out_len  <= len;
          out_size <= size;
          out_ch   <= s1_ch;
        end
      end
    end
  end

endmodule
